// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, port ids, sizing.
package dmem_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } arb_state_t;

  // Port 0 is the core load/store unit, port 1 the peripheral/debug master.
  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DBG  = 1'b1;

  // Default number of 32-bit words in the shared memory.
  localparam int DEFAULT_DEPTH = 64;

endpackage : dmem_arb_pkg

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker: a lone requester always wins,
// a tie goes to the port that was not granted last.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  // One-hot (or zero) grant selection.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_grant == PORT_DBG) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule : rr_arb2

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-ported data memory. A request is
// accepted in IDLE, the memory is accessed for exactly one ACCESS cycle from
// latched fields, and a one-cycle registered response goes back to the
// originating port.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int NPORT = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NPORT-1:0]      req_i,
  input  logic [NPORT-1:0]      we_i,
  input  logic [NPORT-1:0][31:0] addr_i,
  input  logic [NPORT-1:0][31:0] wdata_i,
  output logic [NPORT-1:0]      gnt_o,
  output logic [NPORT-1:0]      resp_valid_o,
  output logic                  resp_err_o,
  output logic [31:0]           rdata_o,
  output logic                  mem_we_o,
  output logic [31:0]           mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  input  logic [31:0]           mem_rdata_i
);

  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

  arb_state_t state_reg, state_next;
  logic       last_grant_reg;
  logic       lat_port_reg;
  logic       lat_we_reg;
  logic [31:0] lat_addr_reg;
  logic [31:0] lat_wdata_reg;
  logic [NPORT-1:0] resp_valid_reg;
  logic       resp_err_reg;
  logic [31:0] rdata_reg;

  logic [1:0] arb_gnt;
  logic [NPORT-1:0] gnt;
  logic       accept;
  logic       grant_port;
  logic       in_range;
  logic       mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  rr_arb2 u_rr_arb2 (
    .req        (req_i),
    .last_grant (last_grant_reg),
    .gnt        (arb_gnt)
  );

  assign grant_port = arb_gnt[PORT_DBG] ? PORT_DBG : PORT_CORE;
  assign in_range   = (lat_addr_reg[31:2] < DEPTH_W);

  // Next-state, grant and memory-side drive; memory pins idle at zero.
  always_comb begin
    state_next = state_reg;
    gnt        = '0;
    accept     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = 32'd0;
    mem_wdata  = 32'd0;
    case (state_reg)
      IDLE: begin
        // Grants are suppressed while reset is held so every output reads 0.
        if (rst_n) begin
          gnt = arb_gnt;
        end
        accept = |gnt;
        if (accept) begin
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        state_next = IDLE;
        mem_we     = lat_we_reg && in_range;
        mem_addr   = lat_addr_reg;
        mem_wdata  = lat_wdata_reg;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; async reset also aborts an in-flight access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Capture the accepted request and remember who won for the next tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_reg <= PORT_DBG;
      lat_port_reg   <= PORT_CORE;
      lat_we_reg     <= 1'b0;
      lat_addr_reg   <= 32'd0;
      lat_wdata_reg  <= 32'd0;
    end else if (accept) begin
      last_grant_reg <= grant_port;
      lat_port_reg   <= grant_port;
      lat_we_reg     <= we_i[grant_port];
      lat_addr_reg   <= addr_i[grant_port];
      lat_wdata_reg  <= wdata_i[grant_port];
    end
  end

  // Register the response at the end of ACCESS; zero in every other cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_reg <= '0;
      resp_err_reg   <= 1'b0;
      rdata_reg      <= 32'd0;
    end else if (state_reg == ACCESS) begin
      resp_valid_reg               <= '0;
      resp_valid_reg[lat_port_reg] <= 1'b1;
      resp_err_reg                 <= !in_range;
      rdata_reg                    <= (!lat_we_reg && in_range) ? mem_rdata_i : 32'd0;
    end else begin
      resp_valid_reg <= '0;
      resp_err_reg   <= 1'b0;
      rdata_reg      <= 32'd0;
    end
  end

  assign gnt_o        = gnt;
  assign resp_valid_o = resp_valid_reg;
  assign resp_err_o   = resp_err_reg;
  assign rdata_o      = rdata_reg;
  assign mem_we_o     = mem_we;
  assign mem_addr_o   = mem_addr;
  assign mem_wdata_o  = mem_wdata;

endmodule : dmem_arbiter

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DEPTH, default 64, number of 32-bit words in the shared data memory.
REQ-002 Parameter NPORT, fixed 2; port 0 is the core load/store unit, port 1 is the peripheral/debug master.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 req_i  input  2  per-port request, held until granted.
REQ-006 we_i  input  2  per-port write enable (1=write, 0=read).
REQ-007 addr_i  input  2x32  per-port byte address; word index = addr[31:2].
REQ-008 wdata_i  input  2x32  per-port write data.
REQ-009 gnt_o  output  2  per-port grant; request accepted on the edge where req_i and gnt_o are both high.
REQ-010 resp_valid_o  output  2  per-port one-cycle response pulse.
REQ-011 resp_err_o  output  1  out-of-range flag, valid with resp_valid_o.
REQ-012 rdata_o  output  32  read data, valid with resp_valid_o (0 for writes).
REQ-013 mem_we_o  output  1  write enable to the memory.
REQ-014 mem_addr_o  output  32  byte address to the memory.
REQ-015 mem_wdata_o  output  32  write data to the memory.
REQ-016 mem_rdata_i  input  32  combinational read data from the memory.

Function
REQ-017 FSM with two states: IDLE and ACCESS.
REQ-018 In IDLE, gnt_o is one-hot or zero; a granted port has req_i high; no grant when no request.
REQ-019 In ACCESS, gnt_o = 0; any incoming requests wait.
REQ-020 Single request in IDLE: granted combinationally in the same cycle.
REQ-021 Both requesting in IDLE: grant the port not granted last (round-robin); last_grant updates on every acceptance.
REQ-022 On acceptance, latch port id, we, addr and wdata, then enter ACCESS for exactly one cycle, then return to IDLE.
REQ-023 In ACCESS, drive mem_addr_o/mem_wdata_o from the latched values, with mem_we_o = latched we AND address in range.
REQ-024 In IDLE, mem_we_o = 0, mem_addr_o = 0 and mem_wdata_o = 0.
REQ-025 Out of range is defined as addr[31:2] >= DEPTH: no write, rdata 0, resp_err_o = 1.
REQ-026 At the end of the ACCESS edge, register the response:
- resp_valid_o is high for the latched port only, for one cycle;
- rdata_o = mem_rdata_i for in-range reads, 0 otherwise.
REQ-027 Latency:
- acceptance at edge N;
- memory access during cycle N+1; write commits at edge N+1;
- response during cycle N+2.
REQ-028 Throughput is one transaction per 2 cycles. A new grant can occur in the same cycle as the previous response.
REQ-029 A continuously requesting port waits at most one transaction of the other port (no starvation).
REQ-030 Outside response cycles, rdata_o = 0 and resp_err_o = 0.

Reset
REQ-031 While rst_n is low:
- state = IDLE, last_grant = 1 (port 0 wins the first tie);
- all latched fields cleared;
- all outputs 0.
REQ-032 Reset asserted during ACCESS aborts the transaction: mem_we_o drops immediately, no write, no response issued.
REQ-033 The first grant is possible in the first cycle after rst_n deasserts.

Structure
REQ-034 Shared package dmem_arb_pkg holds:
- state encoding (IDLE, ACCESS);
- port index constants (PORT_CORE = 0, PORT_DBG = 1);
- default DEPTH.
REQ-035 Sub-module rr_arb2 is a combinational 2-way round-robin picker (req, last_grant -> one-hot gnt); the FSM, latches and response registers live in dmem_arbiter.

Verification
REQ-036 Port 0 writes 0xDEADBEEF to 0x10, then port 0 reads 0x10 -> response at N+2, rdata_o = 0xDEADBEEF, resp_err_o = 0.
REQ-037 Both ports request from reset -> port 0 is granted first, port 1 is granted at the next IDLE cycle; continuous requests from both alternate 0,1,0,1.
REQ-038 Port 1 writes to 0x100 with DEPTH = 64 -> mem_we_o stays 0, resp_err_o = 1, memory unchanged; a read from 0x100 returns 0 with err = 1.
REQ-039 Port 0 request arrives while port 1 is in ACCESS -> gnt_o[0] stays low that cycle; port 0 is granted the next cycle; responses do not overlap.
REQ-040 rst_n pulled low mid-ACCESS on a write of 0x12345678 to 0x20 -> mem_we_o falls asynchronously, the word is not written, no resp_valid_o; after reset, a read of 0x20 returns the prior value.
